aes_round_sequencer: RTL and testbench

Controller for the iterative AES encryption round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey stages, each registered).
- Accepts one 128-bit block per valid/ready handshake.
- Pulses one stage enable per cycle to step the shared datapath through NUM_ROUNDS rounds.
- Requests each round key from the key expander.
- Presents completion to the downstream consumer.
- Sits between the block I/O wrapper and the round datapath. Carries no data itself.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_round_counter.sv | 44 ++++
 rtl/aes_round_sequencer.sv | 134 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round controller.
// Latency: none (definitions only).
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;
    localparam int ROUND_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY0,
        ST_SUB,
        ST_SHIFT,
        ST_MIX,
        ST_ADDKEY,
        ST_DONE
    } seq_state_t;

    // True for the three round counts defined by AES-128/192/256.
    function automatic logic legal_rounds(input int n);
        return (n == AES128_ROUNDS) || (n == AES192_ROUNDS) || (n == AES256_ROUNDS);
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round index register: clears to zero, steps by one, flags the final round.
// Latency: new value visible the cycle after clr_i/inc_i; is_last_o is combinational on the register.
// Backpressure: none; increments saturate at NUM_ROUNDS so the index never wraps.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               is_last_o
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_d;

    // Next round index: clear wins over increment, increment stops at the last round.
    always_comb begin
        round_d = round_q;
        if (clr_i) begin
            round_d = '0;
        end else if (inc_i && (round_q != LAST_ROUND)) begin
            round_d = round_q + 1'b1;
        end
    end

    // Round index register, cleared by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            round_q <= '0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o   = round_q;
    assign is_last_o = (round_q == LAST_ROUND);

endmodule

// File: rtl/aes_round_sequencer.sv
// Steps a shared AES round datapath through NUM_ROUNDS rounds, one stage enable per cycle.
// Latency: with key_ack high, accept at T gives out_valid at T+4*NUM_ROUNDS+1; each key stall adds one cycle.
// Backpressure: in_ready low while busy; DONE holds out_valid until out_ready; key_ack low stalls the key steps.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               load_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               key_req,
    output logic [ROUND_W-1:0] key_round,
    input  logic               key_ack,
    output logic               sub_en,
    output logic               shift_en,
    output logic               mix_en,
    output logic               addkey_en,
    output logic [ROUND_W-1:0] round,
    output logic               busy
);

    if (!legal_rounds(NUM_ROUNDS)) begin : g_bad_num_rounds
        $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
    end

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               is_last;
    logic [ROUND_W-1:0] round_cnt;

    logic               in_ready_q;
    logic               out_valid_q;
    logic               key_req_q;
    logic               sub_en_q;
    logic               shift_en_q;
    logic               mix_en_q;
    logic               busy_q;

    aes_round_counter #(
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_round_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .round_o   (round_cnt),
        .is_last_o (is_last)
    );

    // Next state and round-counter control; the final round skips MIX.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_KEY0;
                    cnt_clr = 1'b1;
                end
            end
            ST_KEY0: begin
                if (key_ack) begin
                    state_d = ST_SUB;
                    cnt_inc = 1'b1;
                end
            end
            ST_SUB:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = is_last ? ST_ADDKEY : ST_MIX;
            ST_MIX:   state_d = ST_ADDKEY;
            ST_ADDKEY: begin
                if (key_ack) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SUB;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register with outputs registered from the decoded next state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            key_req_q   <= 1'b0;
            sub_en_q    <= 1'b0;
            shift_en_q  <= 1'b0;
            mix_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            key_req_q   <= (state_d == ST_KEY0) || (state_d == ST_ADDKEY);
            sub_en_q    <= (state_d == ST_SUB);
            shift_en_q  <= (state_d == ST_SHIFT);
            mix_en_q    <= (state_d == ST_MIX);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // The key-add and load strobes follow their handshakes in the same cycle.
    assign addkey_en = key_req_q & key_ack;
    assign load_en   = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign key_req   = key_req_q;
    assign key_round = round_cnt;
    assign round     = round_cnt;
    assign sub_en    = sub_en_q;
    assign shift_en  = shift_en_q;
    assign mix_en    = mix_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: 10-round and 14-round instances against a step-list model.
// Latency: not applicable.
// Backpressure: exercises key_ack stalls, out_ready holds and in_valid held high while busy.
module tb_aes_round_sequencer;

    typedef struct {
        byte code;
        int  rnd;
    } step_t;

    logic clk = 1'b0;
    logic n_rst;
    logic iv, ka, ordy;
    logic sel14, sel_req;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    logic       a_in_ready, a_load_en, a_out_valid, a_key_req, a_sub, a_shift, a_mix, a_addkey, a_busy;
    logic [3:0] a_key_round, a_round;
    logic       b_in_ready, b_load_en, b_out_valid, b_key_req, b_sub, b_shift, b_mix, b_addkey, b_busy;
    logic [3:0] b_key_round, b_round;

    aes_round_sequencer #(.NUM_ROUNDS(10)) dut10 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(iv & ~sel14), .in_ready(a_in_ready), .load_en(a_load_en),
        .out_valid(a_out_valid), .out_ready(ordy & ~sel14),
        .key_req(a_key_req), .key_round(a_key_round), .key_ack(ka & ~sel14),
        .sub_en(a_sub), .shift_en(a_shift), .mix_en(a_mix), .addkey_en(a_addkey),
        .round(a_round), .busy(a_busy)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(iv & sel14), .in_ready(b_in_ready), .load_en(b_load_en),
        .out_valid(b_out_valid), .out_ready(ordy & sel14),
        .key_req(b_key_req), .key_round(b_key_round), .key_ack(ka & sel14),
        .sub_en(b_sub), .shift_en(b_shift), .mix_en(b_mix), .addkey_en(b_addkey),
        .round(b_round), .busy(b_busy)
    );

    wire [8:0] a_vec = {a_in_ready, a_load_en, a_out_valid, a_key_req, a_sub, a_shift, a_mix, a_addkey, a_busy};
    wire [8:0] b_vec = {b_in_ready, b_load_en, b_out_valid, b_key_req, b_sub, b_shift, b_mix, b_addkey, b_busy};
    // {in_ready, load_en, out_valid, key_req, sub, shift, mix, addkey, busy}
    wire [8:0] o_vec       = sel14 ? b_vec : a_vec;
    wire [3:0] o_round     = sel14 ? b_round : a_round;
    wire [3:0] o_key_round = sel14 ? b_key_round : a_key_round;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and let combinational outputs settle.
    task automatic drive(input logic v, input logic k, input logic r);
        @(negedge clk);
        sel14 = sel_req;
        iv    = v;
        ka    = k;
        ordy  = r;
        #1;
        cyc++;
    endtask

    // One full block: accept, every round step, then the DONE handshake.
    // ack_mode 0: key always ready; 1: random key stalls; 2: three stalls at round-5 key add.
    task automatic run_block(input bit use14, input int ack_mode, input int or_delay, input bit hold_iv);
        step_t    q[$];
        step_t    head;
        int       n, t0, stalls, mixes, keys, stall5, guard;
        bit       is_key;
        logic     kav;
        logic [8:0] exp;

        n       = use14 ? 14 : 10;
        sel_req = use14;
        drive(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        chk("accept", {23'd0, o_vec}, {23'd0, 9'b110_0000_00});
        chk("accept_round", {28'd0, o_round}, 32'd0);

        q.push_back('{"K", 0});
        for (int r = 1; r <= n; r++) begin
            q.push_back('{"S", r});
            q.push_back('{"H", r});
            if (r < n) q.push_back('{"M", r});
            q.push_back('{"A", r});
        end

        stalls = 0; mixes = 0; keys = 0; stall5 = 0; guard = 0;
        while (q.size() > 0 && guard < 600) begin
            guard++;
            head   = q[0];
            is_key = (head.code == "K") || (head.code == "A");
            case (ack_mode)
                1:       kav = ($urandom_range(0, 2) != 0);
                2: begin
                    kav = 1'b1;
                    if (head.code == "A" && head.rnd == 5 && stall5 < 3) begin
                        kav = 1'b0;
                        stall5++;
                    end
                end
                default: kav = 1'b1;
            endcase
            drive(hold_iv ? 1'b1 : 1'($urandom_range(0, 1)), kav, 1'($urandom_range(0, 1)));
            exp = {3'b000, is_key, head.code == "S", head.code == "H", head.code == "M",
                   is_key && kav, 1'b1};
            chk("step_ctl", {23'd0, o_vec}, {23'd0, exp});
            chk("step_round", {28'd0, o_round}, head.rnd);
            if (is_key) chk("key_round", {28'd0, o_key_round}, head.rnd);
            if (o_vec[2]) mixes++;
            if (o_vec[1]) keys++;
            if (!is_key || kav) void'(q.pop_front());
            else stalls++;
        end
        chk("steps_drained", q.size(), 32'd0);

        for (int d = 0; d <= or_delay; d++) begin
            drive(hold_iv ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d == or_delay);
            if (d == 0) chk("latency", cyc - t0, 4 * n + 1 + stalls);
            chk("done_ctl", {23'd0, o_vec}, {23'd0, 9'b001_0000_01});
            chk("done_round", {28'd0, o_round}, n);
        end
        chk("mix_count", mixes, n - 1);
        chk("addkey_count", keys, n + 1);
    endtask

    initial begin
        n_rst = 1'b0; iv = 1'b0; ka = 1'b0; ordy = 1'b0; sel14 = 1'b0; sel_req = 1'b0;
        #1;
        chk("rst_outputs", {24'd0, o_vec[7:0]}, 32'd0);
        chk("rst_round", {28'd0, o_round}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, o_vec[8]}, 32'd1);

        // Nominal 10-round block, then a round-5 key stall, then a held DONE.
        run_block(1'b0, 0, 0, 1'b0);
        run_block(1'b0, 2, 0, 1'b0);
        run_block(1'b0, 0, 5, 1'b0);
        // Accepted the cycle after out_ready, with in_valid held throughout.
        run_block(1'b0, 0, 0, 1'b1);

        // Reset in the middle of round 3 ShiftRows.
        sel_req = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        chk("rst_mid_accept", {31'd0, o_vec[7]}, 32'd1);
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (o_vec[3] && o_round == 4'd3) break;
        end
        chk("reach_r3_shift", {27'd0, o_vec[3], o_round}, {27'd0, 1'b1, 4'd3});
        n_rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {25'd0, o_vec[6:0]}, 32'd0);
        chk("rst_mid_round", {28'd0, o_round}, 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        run_block(1'b0, 0, 0, 1'b0);

        // 14-round instance with key always available.
        run_block(1'b1, 0, 0, 1'b0);

        // Randomised blocks on both instances.
        for (int i = 0; i < 6; i++) begin
            run_block(1'($urandom_range(0, 1)), 1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
